rv_fetch_stage: RTL
===================

// Module: rv_fetch_stage
// PURPOSE
//  Parametrised instruction-fetch front end for the pipelined RISC-V core.
//  Owns the PC, issues in-order requests to a variable-latency instruction memory,
//  buffers responses in a prefetch FIFO and hands {pc, inst} to decode via valid/ready.
//  Execute-stage redirects (branch/jump/trap) flush all wrong-path state.
// PARAMETERS
//  XLEN          32          address/PC width
//  RESET_VECTOR  32'h0000_0000  PC loaded on reset (XLEN bits, [1:0]==0)
//  FIFO_DEPTH    4           prefetch entries; power of 2, >=2
// PORTS
//  clk              in   1     clock, all state on rising edge
//  rst              in   1     synchronous, active-high reset
//  imem_req_valid   out  1     fetch request valid
//  imem_req_ready   in   1     imem accepts request this cycle
//  imem_req_addr    out  XLEN  word-aligned fetch address
//  imem_rsp_valid   in   1     response valid (in order, >=1 cycle after accept)
//  imem_rsp_data    in   32    instruction word
//  redirect_valid   in   1     execute-stage redirect, single-cycle pulse
//  redirect_target  in   XLEN  new PC (already pc+imm, no scaling here)
//  dec_valid        out  1     FIFO head valid
//  dec_ready        in   1     decode accepts head
//  dec_inst         out  32    head instruction
//  dec_pc           out  XLEN  head PC
//  misalign_err     out  1     1-cycle pulse: redirect_target[1:0]!=0
// BEHAVIOUR
//  Reset: pc=RESET_VECTOR, rsp_pc=RESET_VECTOR, FIFO empty, outstanding=0, discard=0;
//   imem_req_valid=0, dec_valid=0, misalign_err=0 in and after reset cycle until state allows.
//  Credit: imem_req_valid = !rst && (fifo_count + outstanding < FIFO_DEPTH).
//   Request accepted when valid&ready -> pc += 4, outstanding += 1. Counters are
//   $clog2(FIFO_DEPTH)+1 bits; sum never exceeds FIFO_DEPTH.
//  Response: outstanding -= 1. If discard>0: drop, discard -= 1. Else push
//   {rsp_pc, imem_rsp_data}, rsp_pc += 4. Push while full is impossible by credit (assert).
//  Decode: dec_valid = !fifo_empty; dec_inst/dec_pc = head (combinational from FIFO).
//   Pop on dec_valid&dec_ready. Push+pop same cycle keeps count.
//  Redirect (redirect_valid & target[1:0]==0), at the edge:
//   pc <= target, rsp_pc <= target, FIFO flushed (count=0);
//   discard <= outstanding_next - kept, i.e. every request in flight after this edge
//   (including one accepted in the redirect cycle) is dropped; a response arriving
//   in the redirect cycle is dropped. A decode handshake in the redirect cycle
//   completes (decode kills it). Redirect overrides the pc += 4 of a same-cycle accept.
//  Misaligned redirect: redirect ignored entirely, misalign_err=1 next cycle only; trap
//   logic upstream issues a later aligned redirect.
//  Back-to-back redirects: each handled independently; discard accumulates correctly.
//  PC wrap: pc arithmetic is modulo 2^XLEN; 0xFFFF_FFFC + 4 -> 0x0.
//  Reset mid-operation: all state cleared; imem shares rst so no stale responses arrive.
//  Latency: earliest request 1 cycle after reset release; rsp->dec_valid 1 cycle.
// STRUCTURE
//  `defines.v gains: `INST_W 32, `NOP 32'h0000_0013, `RESET_VECTOR default.
//  Sub-module fetch_fifo (WIDTH, DEPTH): sync FIFO, push/pop/flush, count, head out,
//   flush has priority over push in the same cycle.
//  Top holds pc, rsp_pc, outstanding, discard and credit logic.
// TESTING
//  Reset, imem 1-cycle latency, dec_ready=1 -> dec_pc 0x0,0x4,0x8.. one per cycle, no bubbles.
//  dec_ready=0, latency 1 -> exactly FIFO_DEPTH(4) requests, then imem_req_valid=0 held.
//  Latency 3, redirect to 0x100 with 3 in flight -> 3 responses dropped, next dec_pc=0x100.
//  Redirect to 0x102 -> misalign_err pulses 1 cycle, sequential fetch continues unchanged.
//  Redirect coincident with accept, response and pop -> no wrong-path inst ever at dec.
//  RESET_VECTOR=0xFFFF_FFF8 -> dec_pc 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.

Source files
------------

// File: rtl/rv_fetch_stage_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rv_fetch_stage_pkg : shared constants and helpers for the fetch front end
// Rev 1.0
// ---------------------------------------------------------------------------
package rv_fetch_stage_pkg;

  localparam int          INST_W               = 32;
  localparam logic [31:0] NOP                  = 32'h0000_0013;
  localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'h0000_0000;

  function automatic logic word_aligned(input logic [1:0] lsb);
    return lsb == 2'b00;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rv_fetch_stage_fifo.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rv_fetch_stage_fifo : synchronous prefetch FIFO, flush beats push
// Rev 1.0
// ---------------------------------------------------------------------------
module rv_fetch_stage_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty,
  output logic [WIDTH-1:0]       head
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             full;
  logic             do_push, do_pop;

  assign empty = (count_q == '0);
  assign full  = (count_q == (AW+1)'(DEPTH));
  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

  always_comb begin
    do_push  = push && !full;
    do_pop   = pop && !empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Data array carries no reset; only pointers define validity.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wr_ptr_q] <= push_data;
  end

  // Upstream credit accounting must never let a response land on a full FIFO.
  always_ff @(posedge clk) begin
    if (!rst && push && !flush) assert (!full);
  end

endmodule
`default_nettype wire

// File: rtl/rv_fetch_stage.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rv_fetch_stage : RISC-V fetch front end - PC, credit-based imem requests,
//                  prefetch buffering and redirect flush
// Rev 1.0
// ---------------------------------------------------------------------------
module rv_fetch_stage
  import rv_fetch_stage_pkg::*;
#(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(RESET_VECTOR_DEFAULT),
  parameter int              FIFO_DEPTH   = 4
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [XLEN-1:0]   imem_req_addr,
  input  logic              imem_rsp_valid,
  input  logic [INST_W-1:0] imem_rsp_data,
  input  logic              redirect_valid,
  input  logic [XLEN-1:0]   redirect_target,
  output logic              dec_valid,
  input  logic              dec_ready,
  output logic [INST_W-1:0] dec_inst,
  output logic [XLEN-1:0]   dec_pc,
  output logic              misalign_err
);

  localparam int              CW        = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW:0]     DEPTH_LIM = (CW+1)'(FIFO_DEPTH);
  localparam logic [XLEN-1:0] INC       = XLEN'(4);

  logic [XLEN-1:0]        pc_q, pc_d;
  logic [XLEN-1:0]        rsp_pc_q, rsp_pc_d;
  logic [CW-1:0]          outstanding_q, outstanding_d;
  logic [CW-1:0]          discard_q, discard_d;
  logic                   misalign_q, misalign_d;
  logic [CW-1:0]          fifo_count;
  logic                   fifo_empty;
  logic [XLEN+INST_W-1:0] fifo_head;
  logic [CW:0]            inflight_sum;
  logic                   req_fire, redirect_ok, push, pop;

  // Entries already buffered plus requests in flight reserve FIFO slots.
  assign inflight_sum   = {1'b0, fifo_count} + {1'b0, outstanding_q};
  assign imem_req_valid = !rst && (inflight_sum < DEPTH_LIM);
  assign imem_req_addr  = pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign redirect_ok    = redirect_valid && word_aligned(redirect_target[1:0]);
  assign push           = imem_rsp_valid && (discard_q == '0) && !redirect_ok;

  assign dec_valid    = !rst && !fifo_empty;
  assign dec_pc       = fifo_head[INST_W +: XLEN];
  assign dec_inst     = fifo_empty ? NOP : fifo_head[INST_W-1:0];
  assign pop          = dec_valid && dec_ready;
  assign misalign_err = !rst && misalign_q;

  always_comb begin
    pc_d          = pc_q;
    rsp_pc_d      = rsp_pc_q;
    outstanding_d = outstanding_q + CW'(req_fire) - CW'(imem_rsp_valid);
    discard_d     = discard_q;
    misalign_d    = redirect_valid && !word_aligned(redirect_target[1:0]);
    if (imem_rsp_valid && (discard_q != '0)) discard_d = discard_q - 1'b1;
    if (req_fire) pc_d = pc_q + INC;
    if (push)     rsp_pc_d = rsp_pc_q + INC;
    // Everything still in flight after this edge belongs to the wrong path.
    if (redirect_ok) begin
      pc_d      = redirect_target;
      rsp_pc_d  = redirect_target;
      discard_d = outstanding_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q          <= RESET_VECTOR;
      rsp_pc_q      <= RESET_VECTOR;
      outstanding_q <= '0;
      discard_q     <= '0;
      misalign_q    <= 1'b0;
    end else begin
      pc_q          <= pc_d;
      rsp_pc_q      <= rsp_pc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      misalign_q    <= misalign_d;
    end
  end

  rv_fetch_stage_fifo #(
    .WIDTH (XLEN + INST_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fetch_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_ok),
    .push      (push),
    .push_data ({rsp_pc_q, imem_rsp_data}),
    .pop       (pop),
    .count     (fifo_count),
    .empty     (fifo_empty),
    .head      (fifo_head)
  );

endmodule
`default_nettype wire
